mul_seq_ctrl: RTL

Multi-cycle multiply sequencer for the execute stage. It borrows the shared ALU and steps it through a 32-bit shift-and-add `MUL` (Rd = Rm × Rs, low 32 bits) using the ALU's ADD command. While it works, it stalls the pipeline. When the product is ready it returns the result and, when S is set, a status-register update. An external mux in the execute stage gives it the ALU whenever `alu_own` is high.

---
 rtl/mul_seq_ctrl_pkg.sv | 31 +++
 rtl/mul_seq_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// ------------------------------------------------------------------
// mul_seq_ctrl_pkg: ALU commands, status bit indices, sequencer states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mul_seq_ctrl_pkg;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_MOV = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0110;
   localparam logic [3:0] ALU_ORR = 4'b0111;
   localparam logic [3:0] ALU_EOR = 4'b1000;

   // Status word layout {z,c,n,v}
   localparam int unsigned SR_Z = 3;
   localparam int unsigned SR_C = 2;
   localparam int unsigned SR_N = 1;
   localparam int unsigned SR_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ------------------------------------------------------------------
// mul_seq_ctrl: 32-step shift-and-add MUL sequencer borrowing the shared ALU.
// Optional build macro: MUL_EARLY_EXIT_EN (exit once the multiplier is exhausted). Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mul_seq_ctrl
   import mul_seq_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] rm,
   input  logic [31:0] rs,
   input  logic        s_bit,
   input  logic [3:0]  sr_in,
   input  logic [31:0] alu_result,
   output logic        alu_own,
   output logic [3:0]  alu_cmd,
   output logic [31:0] alu_val_1,
   output logic [31:0] alu_val_2,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        sr_we,
   output logic [3:0]  sr_out
);

   mul_state_t  state, state_nxt;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] res_q;
   logic [4:0]  cnt;
   logic        s_lat;
   logic        c_lat;
   logic        v_lat;
   logic        last_step;

`ifdef MUL_EARLY_EXIT_EN
   // mplier[31:1] is what remains after this step's shift
   assign last_step = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
`else
   assign last_step = (cnt == 5'd31);
`endif

   assign result = res_q;

   always_comb begin
      state_nxt = state;
      alu_own   = 1'b0;
      alu_cmd   = ALU_NOP;
      alu_val_1 = 32'd0;
      alu_val_2 = 32'd0;
      busy      = 1'b0;
      done      = 1'b0;
      sr_we     = 1'b0;
      sr_out    = 4'd0;
      case (state)
         ST_IDLE: begin
            busy = start;
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            alu_own   = 1'b1;
            alu_cmd   = ALU_ADD;
            alu_val_1 = acc;
            alu_val_2 = mplier[0] ? mcand : 32'd0;
            busy      = 1'b1;
            if (last_step) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done         = 1'b1;
            sr_we        = s_lat;
            sr_out[SR_Z] = (res_q == 32'd0);
            sr_out[SR_C] = c_lat;
            sr_out[SR_N] = res_q[31];
            sr_out[SR_V] = v_lat;
            state_nxt    = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         acc    <= 32'd0;
         mcand  <= 32'd0;
         mplier <= 32'd0;
         res_q  <= 32'd0;
         cnt    <= 5'd0;
         s_lat  <= 1'b0;
         c_lat  <= 1'b0;
         v_lat  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc    <= 32'd0;
                  mcand  <= rm;
                  mplier <= rs;
                  cnt    <= 5'd0;
                  s_lat  <= s_bit;
                  c_lat  <= sr_in[SR_C];
                  v_lat  <= sr_in[SR_V];
               end
            end
            ST_RUN: begin
               acc    <= alu_result;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
               // Capture the final sum directly so result is valid during DONE
               if (last_step) res_q <= alu_result;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
